// File: rtl/rom_bus_arbiter_if.sv
// rtl/rom_bus_arbiter_if.sv - requester and flash-pin signal bundle for rom_bus_arbiter
//
// Requester side:
//   rd_req/rd_addr -> rd_data/rd_ack     instruction-fetch reads
//   wr_req/wr_addr/wr_data -> wr_ack     ROM programming writes
//   busy                                 arbiter not in IDLE
// Flash side:
//   rom_addr, rom_dout, rom_dout_en      address and data pad drive
//   rom_din                              data returned by the flash
//   rom_ce_n, rom_oe_n, rom_we_n         active-low strobes
// Modports: slave = arbiter view, master = requester/board view.

interface rom_bus_arbiter_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_ack;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        busy;
    logic [31:0] rom_addr;
    logic [15:0] rom_dout;
    logic        rom_dout_en;
    logic [15:0] rom_din;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic        rom_we_n;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, rom_din,
        output rd_data, rd_ack, wr_ack, busy,
               rom_addr, rom_dout, rom_dout_en, rom_ce_n, rom_oe_n, rom_we_n
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, rom_din,
        input  rd_data, rd_ack, wr_ack, busy,
               rom_addr, rom_dout, rom_dout_en, rom_ce_n, rom_oe_n, rom_we_n
    );
endinterface

// File: rtl/rom_bus_arbiter.sv
// rtl/rom_bus_arbiter.sv - round-robin read/write arbiter and strobe sequencer for the flash bus
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - rom_bus_arbiter_if.slave: read/write request handshakes and flash pins
// Parameters:
//   SETUP_CYC  (0..15) ce-only cycles before oe/we, 0 skips the phase
//   ACCESS_CYC (1..15) cycles of oe (read) or we (write)
//   HOLD_CYC   (0..15) ce/address/data hold cycles after oe/we, 0 skips the phase

module rom_bus_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    rom_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Phase counters count down from N-1 to 0; a zero-length phase is never entered.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic        last_q, last_d;      // 1 = write was granted last
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [31:0] rom_addr_q, rom_addr_d;
    logic [15:0] rom_dout_q, rom_dout_d;
    logic        rom_dout_en_q, rom_dout_en_d;
    logic        rd_ack_q, rd_ack_d;
    logic        wr_ack_q, wr_ack_d;

    logic        grant_wr;
    logic        on_bus;

    // State register; async reset clears the pins without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            op_wr_q       <= 1'b0;
            last_q        <= 1'b1;
            addr_q        <= 32'd0;
            wdata_q       <= 16'd0;
            rd_data_q     <= 16'd0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            rom_addr_q    <= 32'd0;
            rom_dout_q    <= 16'd0;
            rom_dout_en_q <= 1'b0;
            rd_ack_q      <= 1'b0;
            wr_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_wr_q       <= op_wr_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_data_q     <= rd_data_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            rom_addr_q    <= rom_addr_d;
            rom_dout_q    <= rom_dout_d;
            rom_dout_en_q <= rom_dout_en_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
        end
    end

    // On a tie the side not granted last wins.
    assign grant_wr = bus.wr_req && (!bus.rd_req || !last_q);

    // Next-state and transaction-context logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rd_req || bus.wr_req) begin
                    op_wr_d = grant_wr;
                    last_d  = grant_wr;
                    addr_d  = grant_wr ? bus.wr_addr : bus.rd_addr;
                    wdata_d = grant_wr ? bus.wr_data : 16'd0;
                    if (SETUP_CYC == 0) begin
                        state_d = ST_ACCESS;
                        cnt_d   = ACCESS_LOAD;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                    cnt_d   = ACCESS_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Flash data is sampled on the edge closing the last oe cycle.
                    if (!op_wr_q) begin
                        rd_data_d = bus.rom_din;
                    end
                    if (HOLD_CYC == 0) begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pin outputs decoded from the next state so they are glitch-free flops.
    always_comb begin
        on_bus        = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        ce_n_d        = !on_bus;
        oe_n_d        = !((state_d == ST_ACCESS) && !op_wr_d);
        we_n_d        = !((state_d == ST_ACCESS) && op_wr_d);
        rom_addr_d    = on_bus ? addr_d : 32'd0;
        rom_dout_en_d = on_bus && op_wr_d;
        rom_dout_d    = (on_bus && op_wr_d) ? wdata_d : 16'd0;
        rd_ack_d      = (state_d == ST_DONE) && !op_wr_d;
        wr_ack_d      = (state_d == ST_DONE) && op_wr_d;
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_ack      = rd_ack_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rom_addr    = rom_addr_q;
    assign bus.rom_dout    = rom_dout_q;
    assign bus.rom_dout_en = rom_dout_en_q;
    assign bus.rom_ce_n    = ce_n_q;
    assign bus.rom_oe_n    = oe_n_q;
    assign bus.rom_we_n    = we_n_q;

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb/tb_rom_bus_arbiter.sv - directed self-checking bench for rom_bus_arbiter

module tb_rom_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rom_bus_arbiter_if bus_d ();
    rom_bus_arbiter_if bus_m ();

    rom_bus_arbiter u_dut_def (
        .clk (clk),
        .rst (rst),
        .bus (bus_d.slave)
    );

    rom_bus_arbiter #(
        .SETUP_CYC  (0),
        .ACCESS_CYC (1),
        .HOLD_CYC   (0)
    ) u_dut_min (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle; req is raised now and dropped after cycle drop_k is checked.
    task automatic run_read(input logic [31:0] addr, input logic [15:0] din, input int drop_k);
        bus_d.rd_addr = addr;
        bus_d.rom_din = din;
        bus_d.rd_req  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_val($sformatf("rd_ce_n@%0d", k), 32'(bus_d.rom_ce_n), (k <= 5) ? 32'd0 : 32'd1);
            check_val($sformatf("rd_oe_n@%0d", k), 32'(bus_d.rom_oe_n), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
            check_val($sformatf("rd_we_n@%0d", k), 32'(bus_d.rom_we_n), 32'd1);
            check_val($sformatf("rd_dout_en@%0d", k), 32'(bus_d.rom_dout_en), 32'd0);
            check_val($sformatf("rd_addr@%0d", k), bus_d.rom_addr, (k <= 5) ? addr : 32'd0);
            check_val($sformatf("rd_ack@%0d", k), 32'(bus_d.rd_ack), (k == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("rd_busy@%0d", k), 32'(bus_d.busy), (k <= 6) ? 32'd1 : 32'd0);
            if (k == 6) check_val("rd_data", 32'(bus_d.rd_data), 32'(din));
            if (k == drop_k) bus_d.rd_req = 1'b0;
        end
    endtask

    initial begin
        bus_d.rd_req = 0; bus_d.rd_addr = 0; bus_d.wr_req = 0; bus_d.wr_addr = 0;
        bus_d.wr_data = 0; bus_d.rom_din = 0;
        bus_m.rd_req = 0; bus_m.rd_addr = 0; bus_m.wr_req = 0; bus_m.wr_addr = 0;
        bus_m.wr_data = 0; bus_m.rom_din = 0;

        // Reset state
        step();
        step();
        check_val("rst_ce_n", 32'(bus_d.rom_ce_n), 32'd1);
        check_val("rst_oe_n", 32'(bus_d.rom_oe_n), 32'd1);
        check_val("rst_we_n", 32'(bus_d.rom_we_n), 32'd1);
        check_val("rst_addr", bus_d.rom_addr, 32'd0);
        check_val("rst_dout", 32'(bus_d.rom_dout), 32'd0);
        check_val("rst_dout_en", 32'(bus_d.rom_dout_en), 32'd0);
        check_val("rst_rd_data", 32'(bus_d.rd_data), 32'd0);
        check_val("rst_acks", {30'd0, bus_d.rd_ack, bus_d.wr_ack}, 32'd0);
        check_val("rst_busy", 32'(bus_d.busy), 32'd0);
        rst = 1'b1;

        // Single read with defaults, request raised in the first IDLE clock
        run_read(32'h0000_1234, 16'hBEEF, 6);

        // Single write with defaults
        bus_d.wr_addr = 32'h40;
        bus_d.wr_data = 16'hA5A5;
        bus_d.wr_req  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_val($sformatf("wr_ce_n@%0d", k), 32'(bus_d.rom_ce_n), (k <= 5) ? 32'd0 : 32'd1);
            check_val($sformatf("wr_we_n@%0d", k), 32'(bus_d.rom_we_n), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
            check_val($sformatf("wr_oe_n@%0d", k), 32'(bus_d.rom_oe_n), 32'd1);
            check_val($sformatf("wr_dout@%0d", k), 32'(bus_d.rom_dout), (k <= 5) ? 32'hA5A5 : 32'd0);
            check_val($sformatf("wr_dout_en@%0d", k), 32'(bus_d.rom_dout_en), (k <= 5) ? 32'd1 : 32'd0);
            check_val($sformatf("wr_addr@%0d", k), bus_d.rom_addr, (k <= 5) ? 32'h40 : 32'd0);
            check_val($sformatf("wr_ack@%0d", k), 32'(bus_d.wr_ack), (k == 6) ? 32'd1 : 32'd0);
            check_val($sformatf("wr_rd_ack@%0d", k), 32'(bus_d.rd_ack), 32'd0);
            if (k == 6) bus_d.wr_req = 1'b0;
        end

        // Both requests held: last grant was write, so read, write, read, write
        bus_d.rd_addr = 32'h100;
        bus_d.wr_addr = 32'h200;
        bus_d.wr_data = 16'h0F0F;
        bus_d.rom_din = 16'h2222;
        bus_d.rd_req  = 1'b1;
        bus_d.wr_req  = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            check_val($sformatf("rr_rd_ack@%0d", k), 32'(bus_d.rd_ack), (k == 6 || k == 20) ? 32'd1 : 32'd0);
            check_val($sformatf("rr_wr_ack@%0d", k), 32'(bus_d.wr_ack), (k == 13 || k == 27) ? 32'd1 : 32'd0);
            if (k == 3 || k == 17) check_val($sformatf("rr_oe_n@%0d", k), 32'(bus_d.rom_oe_n), 32'd0);
            if (k == 10 || k == 24) begin
                check_val($sformatf("rr_we_n@%0d", k), 32'(bus_d.rom_we_n), 32'd0);
                check_val($sformatf("rr_waddr@%0d", k), bus_d.rom_addr, 32'h200);
            end
            if (k == 8) check_val("rr_dout_en@8", 32'(bus_d.rom_dout_en), 32'd1);
            if (k == 15) check_val("rr_raddr@15", bus_d.rom_addr, 32'h100);
            if (k == 27) begin
                bus_d.rd_req = 1'b0;
                bus_d.wr_req = 1'b0;
            end
        end
        check_val("rr_busy_end", 32'(bus_d.busy), 32'd0);

        // Async reset during the second ACCESS cycle of a write
        bus_d.wr_addr = 32'h300;
        bus_d.wr_data = 16'h5A5A;
        bus_d.wr_req  = 1'b1;
        step();
        step();
        step();
        check_val("ar_we_n_pre", 32'(bus_d.rom_we_n), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_val("ar_ce_n", 32'(bus_d.rom_ce_n), 32'd1);
        check_val("ar_we_n", 32'(bus_d.rom_we_n), 32'd1);
        check_val("ar_dout_en", 32'(bus_d.rom_dout_en), 32'd0);
        check_val("ar_addr", bus_d.rom_addr, 32'd0);
        check_val("ar_busy", 32'(bus_d.busy), 32'd0);
        bus_d.wr_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("ar_wr_ack@%0d", k), 32'(bus_d.wr_ack), 32'd0);
        end
        rst = 1'b1;
        run_read(32'h88, 16'h1357, 6);

        // Read request dropped in the first ACCESS cycle still completes
        run_read(32'hABCD_0002, 16'hC0DE, 2);

        // Minimum timing: S=0, A=1, H=0
        bus_m.rd_addr = 32'h44;
        bus_m.rom_din = 16'h7E7E;
        bus_m.rd_req  = 1'b1;
        step();
        check_val("min_ce_n@1", 32'(bus_m.rom_ce_n), 32'd0);
        check_val("min_oe_n@1", 32'(bus_m.rom_oe_n), 32'd0);
        check_val("min_addr@1", bus_m.rom_addr, 32'h44);
        check_val("min_ack@1", 32'(bus_m.rd_ack), 32'd0);
        step();
        check_val("min_ce_n@2", 32'(bus_m.rom_ce_n), 32'd1);
        check_val("min_oe_n@2", 32'(bus_m.rom_oe_n), 32'd1);
        check_val("min_ack@2", 32'(bus_m.rd_ack), 32'd1);
        check_val("min_rd_data", 32'(bus_m.rd_data), 32'h7E7E);
        bus_m.rd_req = 1'b0;
        step();
        check_val("min_ack@3", 32'(bus_m.rd_ack), 32'd0);
        check_val("min_busy@3", 32'(bus_m.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
